// File: rtl/clock_cfg_pkg.sv
// Shared constants for the clock configuration loader: opcodes, default
// geometry and the parser FSM state encoding.
// Build option: CLOCK_CFG_TIMEOUT_EN adds an idle timeout to the parser.
package clock_cfg_pkg;

    localparam int N_DIV_DEF   = 4;
    localparam int DIV_W_DEF   = 10;
    localparam int N_CLK_DEF   = 8;
    localparam int TIMEOUT_DEF = 255;

    // WR_DIV is 0x1i: upper nibble selects the opcode, lower bits pick the divider.
    localparam logic [3:0] OP_WR_DIV_NIB = 4'h1;
    localparam logic [7:0] OP_WR_JOINS   = 8'h20;
    localparam logic [7:0] OP_COMMIT     = 8'h30;
    localparam logic [7:0] OP_CLK_RST    = 8'h40;
    localparam logic [7:0] OP_CLR_ERR    = 8'h50;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DIV_LO   = 3'd1,
        ST_DIV_HI   = 3'd2,
        ST_JOINS    = 3'd3,
        ST_RST_MASK = 3'd4
    } state_t;

endpackage

// File: rtl/clock_cfg_shadow.sv
// Double-buffered register bank: shadow divider limits and join mask take
// byte writes; a commit strobe copies every shadow to the active outputs in
// a single cycle and raises cfg_updated for that one cycle.
module clock_cfg_shadow
    import clock_cfg_pkg::*;
#(
    parameter int N_DIV = N_DIV_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int N_CLK = N_CLK_DEF,
    parameter int IDX_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             wr_byte,
    input  logic [IDX_W-1:0]       div_idx,
    input  logic                   div_lo_we,
    input  logic                   div_hi_we,
    input  logic                   joins_we,
    input  logic                   commit,
    output logic [N_DIV*DIV_W-1:0] cfg_div_limits,
    output logic [N_CLK-1:0]       cfg_clk_joins,
    output logic                   cfg_updated
);

    logic [DIV_W-1:0] shadow_div [N_DIV];
    logic [N_CLK-1:0] shadow_joins;

    // Shadow writes: low byte, truncated high byte, join mask.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_DIV; i++) shadow_div[i] <= '0;
            shadow_joins <= '0;
        end else begin
            if (div_lo_we) shadow_div[div_idx][7:0] <= wr_byte;
            if (div_hi_we) shadow_div[div_idx][DIV_W-1:8] <= wr_byte[DIV_W-9:0];
            if (joins_we)  shadow_joins <= wr_byte[N_CLK-1:0];
        end
    end

    // Commit: copy all shadows to the active outputs at once and pulse cfg_updated.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_div_limits <= '0;
            cfg_clk_joins  <= '0;
            cfg_updated    <= 1'b0;
        end else begin
            cfg_updated <= commit;
            if (commit) begin
                for (int i = 0; i < N_DIV; i++) cfg_div_limits[i*DIV_W +: DIV_W] <= shadow_div[i];
                cfg_clk_joins <= shadow_joins;
            end
        end
    end

endmodule

// File: rtl/clock_cfg_loader.sv
// Byte-stream command parser feeding clocks_module. Headers are decoded in
// IDLE; payload bytes go to the shadow bank; COMMIT publishes the whole
// configuration atomically. CLK_RST produces a one-cycle reset-mask pulse.
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high; in_valid low simply holds the parser state.
// Build option: CLOCK_CFG_TIMEOUT_EN aborts a command stalled mid-payload.
module clock_cfg_loader
    import clock_cfg_pkg::*;
#(
    parameter int N_DIV   = N_DIV_DEF,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int N_CLK   = N_CLK_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_DIV*DIV_W-1:0] cfg_div_limits,
    output logic [N_CLK-1:0]       cfg_clk_joins,
    output logic                   en_clk_reset,
    output logic [N_CLK-1:0]       clk_reset,
    output logic                   cfg_updated,
    output logic                   err
);

    localparam int         IDX_W     = (N_DIV > 1) ? $clog2(N_DIV) : 1;
    localparam logic [4:0] N_DIV_L   = 5'(N_DIV);
    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] div_idx_q;
    logic             hs;
    logic             idx_load, div_lo_we, div_hi_we, joins_we, commit;
    logic             rst_fire, err_set, err_clr;
    logic             timeout_hit;

    assign hs = in_valid & in_ready;

`ifdef CLOCK_CFG_TIMEOUT_EN
    logic [7:0] idle_cnt_q;

    // Count idle cycles inside a command; any handshake or return to IDLE restarts it.
    always_ff @(posedge clk) begin
        if (reset || hs || state_q == ST_IDLE || timeout_hit) idle_cnt_q <= '0;
        else                                                  idle_cnt_q <= idle_cnt_q + 8'd1;
    end

    assign timeout_hit = (state_q != ST_IDLE) && !hs && (idle_cnt_q == TIMEOUT_L);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_L;
    assign timeout_hit    = 1'b0;
`endif

    // State, ready, divider index, pulse outputs and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            in_ready     <= 1'b0;
            div_idx_q    <= '0;
            en_clk_reset <= 1'b0;
            clk_reset    <= '0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_ready     <= 1'b1;
            en_clk_reset <= rst_fire;
            clk_reset    <= rst_fire ? in_data[N_CLK-1:0] : '0;
            if (idx_load) div_idx_q <= in_data[IDX_W-1:0];
            // A fresh error in the same cycle as CLR_ERR keeps err set.
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    // Header decode and payload sequencing.
    always_comb begin
        state_d   = state_q;
        idx_load  = 1'b0;
        div_lo_we = 1'b0;
        div_hi_we = 1'b0;
        joins_we  = 1'b0;
        commit    = 1'b0;
        rst_fire  = 1'b0;
        err_set   = 1'b0;
        err_clr   = 1'b0;
        if (timeout_hit) begin
            state_d = ST_IDLE;
            err_set = 1'b1;
        end else if (hs) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_data[7:4] == OP_WR_DIV_NIB && {1'b0, in_data[3:0]} < N_DIV_L) begin
                        idx_load = 1'b1;
                        state_d  = ST_DIV_LO;
                    end else if (in_data == OP_WR_JOINS) begin
                        state_d = ST_JOINS;
                    end else if (in_data == OP_COMMIT) begin
                        commit = 1'b1;
                    end else if (in_data == OP_CLK_RST) begin
                        state_d = ST_RST_MASK;
                    end else if (in_data == OP_CLR_ERR) begin
                        err_clr = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                ST_DIV_LO: begin
                    div_lo_we = 1'b1;
                    state_d   = ST_DIV_HI;
                end
                ST_DIV_HI: begin
                    div_hi_we = 1'b1;
                    // Bits beyond the divider width are dropped but flagged.
                    err_set   = ((in_data >> (DIV_W - 8)) != 8'h00);
                    state_d   = ST_IDLE;
                end
                ST_JOINS: begin
                    joins_we = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_RST_MASK: begin
                    rst_fire = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    clock_cfg_shadow #(
        .N_DIV (N_DIV),
        .DIV_W (DIV_W),
        .N_CLK (N_CLK),
        .IDX_W (IDX_W)
    ) u_shadow (
        .clk            (clk),
        .reset          (reset),
        .wr_byte        (in_data),
        .div_idx        (idx_load ? in_data[IDX_W-1:0] : div_idx_q),
        .div_lo_we      (div_lo_we),
        .div_hi_we      (div_hi_we),
        .joins_we       (joins_we),
        .commit         (commit),
        .cfg_div_limits (cfg_div_limits),
        .cfg_clk_joins  (cfg_clk_joins),
        .cfg_updated    (cfg_updated)
    );

endmodule
